// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared types and defaults for the UART transmit feeder path.
//   feeder_state_e  - launch FSM states, 2-bit encoding
//   UART_DATA_WIDTH - default byte width shared by feeder, FIFO and bus
package uart_tx_pkg;

  localparam int unsigned UART_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if: groups the host push handshake and the transmit
// controller launch handshake of uart_tx_feeder.
//   in_data/in_valid/in_ready  - host byte stream (valid/ready)
//   tx_busy                    - controller Busy
//   tx_data/tx_data_valid      - byte and launch pulse to the controller
// Modports: master = host + controller side, slave = feeder side.
interface uart_tx_feeder_if
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  tx_busy;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_data_valid;

  modport master (
    output in_data, in_valid, tx_busy,
    input  in_ready, tx_data, tx_data_valid
  );

  modport slave (
    input  in_data, in_valid, tx_busy,
    output in_ready, tx_data, tx_data_valid
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with a combinational head.
//   push/wdata - write when not full (ignored when full, even with a pop)
//   pop/rdata  - rdata is the current head; pop advances when not empty
//   full/empty/count - occupancy flags and count, updated on the edge
// Pointers wrap modulo DEPTH (DEPTH must be a power of two, >= 2).
module uart_sync_fifo
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; contents behind the pointers are don't-care.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers host bytes and launches them one at a time into
// the UART transmit controller, relaunching when Busy never appears.
//   clk, rst     - rising-edge clock, synchronous active-high reset
//   bus (slave)  - host push handshake + controller launch handshake
//   fifo_count   - FIFO occupancy
//   feeder_busy  - FSM not idle or FIFO holds data
//   timeout_err  - one-cycle pulse on each launch timeout / relaunch
module uart_tx_feeder
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_tx_feeder_if.slave        bus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   feeder_busy,
  output logic                   timeout_err
);

  localparam int unsigned TW = $clog2(BUSY_TIMEOUT);

  feeder_state_e         state;
  logic [TW-1:0]         timer;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  tx_valid_q;
  logic [DATA_WIDTH-1:0] head;
  logic                  full;
  logic                  empty;
  logic                  launch;

  // Pop only on the IDLE->LAUNCH edge, and only once the controller is idle.
  assign launch = (state == IDLE) && !empty && !bus.tx_busy;

  assign bus.in_ready      = !full;
  assign bus.tx_data       = tx_data_q;
  assign bus.tx_data_valid = tx_valid_q;
  assign feeder_busy       = (state != IDLE) || !empty;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.in_valid),
    .pop   (launch),
    .wdata (bus.in_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Pulse outputs are set on the edge entering LAUNCH so they are high for
  // exactly the LAUNCH cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      tx_valid_q  <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (launch) begin
            tx_data_q  <= head;
            tx_valid_q <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          timer <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state <= WAIT_DONE;
          end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
            // Resend the held byte; the FIFO is not popped again.
            timeout_err <= 1'b1;
            tx_valid_q  <= 1'b1;
            state       <= LAUNCH;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: self-checking bench for uart_tx_feeder. A queue-based
// reference predicts FIFO contents, launch edges, relaunches and held data;
// a small controller model answers launch pulses with a Busy frame.
module tb_uart_tx_feeder;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned BT    = 4;

  logic clk = 1'b0;
  logic rst;
  logic [$clog2(DEPTH):0] fifo_count;
  logic feeder_busy;
  logic timeout_err;

  always #5 clk = ~clk;

  uart_tx_feeder_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_feeder #(
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH),
    .BUSY_TIMEOUT (BT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .fifo_count  (fifo_count),
    .feeder_busy (feeder_busy),
    .timeout_err (timeout_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_data = '0;
  int edge_n        = 0;
  int free_edge     = 0;   // first edge at which a new launch may occur
  int next_relaunch = 0;
  int relaunch_left = 0;
  int launches      = 0;

  // Controller model / scenario knobs
  int frame_len   = 10;
  int ignore_n    = 0;     // launch attempts the controller ignores
  int cur_len     = 10;
  int ign_left    = 0;
  int busy_cnt    = 0;
  bit hold        = 1'b0;
  bit prev_v      = 1'b0;
  int pulses_seen = 0;
  int terr_seen   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic tick();
    logic          b_iv;
    logic [DW-1:0] b_id;
    logic          b_busy;
    logic          b_rst;
    logic          exp_v;
    logic          exp_t;
    bit            full_b;
    b_iv   = bus.in_valid;
    b_id   = bus.in_data;
    b_busy = bus.tx_busy;
    b_rst  = rst;
    @(posedge clk);
    #1;
    edge_n++;
    exp_v = 1'b0;
    exp_t = 1'b0;
    if (b_rst) begin
      q.delete();
      m_data        = '0;
      relaunch_left = 0;
      free_edge     = edge_n + 1;
    end else begin
      full_b = (q.size() == DEPTH);
      if (edge_n >= free_edge && q.size() != 0 && !b_busy) begin
        m_data        = q.pop_front();
        exp_v         = 1'b1;
        cur_len       = frame_len;
        ign_left      = ignore_n;
        relaunch_left = ignore_n;
        next_relaunch = edge_n + BT + 1;
        free_edge     = edge_n + ignore_n * (BT + 1) + cur_len + 3;
        launches++;
      end else if (relaunch_left > 0 && edge_n == next_relaunch) begin
        exp_v = 1'b1;
        exp_t = 1'b1;
        relaunch_left--;
        next_relaunch += BT + 1;
      end
      if (b_iv && !full_b) q.push_back(b_id);
    end

    check("tx_data_valid", 32'(bus.tx_data_valid), 32'(exp_v));
    check("tx_data",       32'(bus.tx_data),       32'(m_data));
    check("timeout_err",   32'(timeout_err),       32'(exp_t));
    check("fifo_count",    32'(fifo_count),        32'(q.size()));
    check("in_ready",      32'(bus.in_ready),      32'(q.size() < DEPTH));
    check("feeder_busy",   32'(feeder_busy),       32'(q.size() != 0 || edge_n < free_edge - 1));

    if (bus.tx_data_valid === 1'b1) pulses_seen++;
    if (timeout_err === 1'b1) terr_seen++;

    // Controller: registers Busy one edge after sampling Data_Valid.
    if (busy_cnt > 0) busy_cnt--;
    if (prev_v) begin
      if (ign_left > 0) ign_left--;
      else busy_cnt = cur_len;
    end
    bus.tx_busy = (busy_cnt > 0) || hold;
    prev_v = (bus.tx_data_valid === 1'b1);
  endtask

  task automatic push_byte(input logic [DW-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic run_until_idle(input int limit);
    int n;
    n = 0;
    while ((q.size() != 0 || edge_n < free_edge) && n < limit) begin
      tick();
      n++;
    end
    check("drain_idle", 32'(feeder_busy), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int t0;
    int n;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.tx_busy  = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_count",   32'(fifo_count),        32'(0));
    check("rst_ready",   32'(bus.in_ready),      32'(1));
    check("rst_tx_data", 32'(bus.tx_data),       32'(0));
    check("rst_valid",   32'(bus.tx_data_valid), 32'(0));
    check("rst_terr",    32'(timeout_err),       32'(0));
    check("rst_fbusy",   32'(feeder_busy),       32'(0));

    // Single byte
    frame_len = 10;
    push_byte(8'hA5);
    tick();
    check("single_valid", 32'(bus.tx_data_valid), 32'(1));
    check("single_data",  32'(bus.tx_data),       32'(8'hA5));
    run_until_idle(100);

    // Burst to full while the controller is held busy
    frame_len = 5;
    hold = 1'b1;
    bus.tx_busy = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      bus.in_data = DW'(i);
      tick();
    end
    check("burst_count", 32'(fifo_count),   32'(8));
    check("burst_ready", 32'(bus.in_ready), 32'(0));
    // Release: launch edge coincides with a refused push
    bus.in_data = 8'h99;
    hold = 1'b0;
    bus.tx_busy = (busy_cnt > 0);
    tick();
    bus.in_valid = 1'b0;
    check("fullpop_count", 32'(fifo_count),        32'(7));
    check("fullpop_valid", 32'(bus.tx_data_valid), 32'(1));
    check("fullpop_data",  32'(bus.tx_data),       32'(8'h01));
    run_until_idle(300);

    // Timeout: controller acknowledges only the third attempt
    ignore_n  = 2;
    frame_len = 3;
    t0 = terr_seen;
    p0 = pulses_seen;
    push_byte(8'h3C);
    run_until_idle(100);
    check("timeout_pulses", 32'(terr_seen - t0),   32'(2));
    check("timeout_launch", 32'(pulses_seen - p0), 32'(3));
    ignore_n = 0;

    // Pointer wrap with low occupancy
    p0 = pulses_seen;
    n = 0;
    while (pulses_seen - p0 < 20 && n < 2000) begin
      bus.in_valid = (q.size() < 3) && ($urandom_range(0, 1) == 1);
      bus.in_data  = DW'($urandom);
      frame_len    = $urandom_range(1, 4);
      tick();
      n++;
    end
    bus.in_valid = 1'b0;
    check("wrap_pulses", 32'(pulses_seen - p0 >= 20), 32'(1));
    run_until_idle(300);

    // Fully random traffic with occasional ignored launches
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = ($urandom_range(0, 1) == 1);
      bus.in_data  = DW'($urandom);
      frame_len    = $urandom_range(1, 6);
      ignore_n     = ($urandom_range(0, 3) == 0) ? 1 : 0;
      tick();
    end
    bus.in_valid = 1'b0;
    ignore_n = 0;
    run_until_idle(1000);

    // Reset during WAIT_DONE with bytes queued
    frame_len = 20;
    push_byte(8'h11);
    push_byte(8'h21);
    push_byte(8'h22);
    push_byte(8'h23);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_count", 32'(fifo_count),        32'(0));
    check("midrst_ready", 32'(bus.in_ready),      32'(1));
    check("midrst_data",  32'(bus.tx_data),       32'(0));
    check("midrst_valid", 32'(bus.tx_data_valid), 32'(0));
    p0 = pulses_seen;
    for (int i = 0; i < 30; i++) tick();
    check("midrst_no_pulse", 32'(pulses_seen - p0), 32'(0));
    frame_len = 4;
    push_byte(8'h77);
    run_until_idle(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Upstream buffering and launch stage for the UART transmit path. Accepts bytes from the host on a valid/ready handshake and stores them in a small synchronous FIFO. Hands each byte to the transmit controller as a single-cycle `Data_Valid` pulse, then tracks the controller's `Busy` so that exactly one byte is in flight at a time. Detects a controller that never acknowledges a launch.

## Interface
- `DATA_WIDTH`, 8: byte width; must match the serializer input.
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `BUSY_TIMEOUT`, 4: cycles to wait in WAIT_BUSY for `tx_busy` before relaunching; at least 2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_data` in DATA_WIDTH: host byte.
- `in_valid` in 1: host byte valid.
- `in_ready` out 1: FIFO can accept; equals not full.
- `tx_busy` in 1: transmit controller `Busy`.
- `tx_data` out DATA_WIDTH: byte for serializer; registered.
- `tx_data_valid` out 1: launch pulse to controller `Data_Valid`; registered.
- `fifo_count` out $clog2(DEPTH)+1: occupancy.
- `feeder_busy` out 1: state ≠ IDLE or FIFO not empty.
- `timeout_err` out 1: one-cycle pulse per launch timeout.

## Operation
- Push when `in_valid && in_ready` at an edge. Pop happens only on the IDLE→LAUNCH transition, and the head is written into `tx_data` on that same edge.
- Full: `in_ready`=0; a push attempt is ignored, even if a pop occurs in the same cycle. Empty: no launch. There is no bypass, so a byte pushed into an empty FIFO is popped no earlier than the next edge.
- Push and pop on the same edge when the FIFO is neither full nor empty: count unchanged. Read and write pointers wrap modulo DEPTH.
- FSM:
  - IDLE: if FIFO is not empty and `tx_busy`=0, pop, load `tx_data`, go to LAUNCH.
  - LAUNCH: `tx_data_valid`=1 for this cycle only. Clear the timer. Go to WAIT_BUSY unconditionally.
  - WAIT_BUSY:
    - If `tx_busy`=1, go to WAIT_DONE.
    - Otherwise, when the timer reaches BUSY_TIMEOUT−1, pulse `timeout_err` and go to LAUNCH, resending the held `tx_data` without a new pop.
    - Otherwise increment the timer.
  - WAIT_DONE: when `tx_busy`=0, go to IDLE.
- `tx_data` remains stable from the load edge until the next pop.
- Reset: state IDLE, pointers/count/timer 0, `tx_data`=0, `tx_data_valid`=0, `timeout_err`=0, `feeder_busy`=0, `in_ready`=1. FIFO contents are discarded. Reset during WAIT_DONE abandons the in-flight byte.

## Timing
- A push accepted at edge N into an empty FIFO with the feeder idle and `tx_busy`=0 gives `tx_data`/`tx_data_valid` valid after edge N+1. The pulse lasts exactly one cycle.
- The controller registers `Busy` one edge after sampling `Data_Valid`. A correctly behaving controller is therefore seen in WAIT_BUSY within 2 cycles, below the default timeout.
- IDLE samples `tx_busy`=0 before launching, so a relaunch can never collide with a frame still in progress. Minimum spacing between pulses is LAUNCH + WAIT_BUSY + frame + WAIT_DONE + IDLE.
- `fifo_count` and `in_ready` update on the edge after the push or pop that changes them.

## Structure
- Package `uart_tx_pkg`:
  - state enum `{IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE}`, 2-bit encoding.
  - shared `DATA_WIDTH` default.
- Sub-module `uart_sync_fifo`: parameters DATA_WIDTH and DEPTH; ports push, pop, wdata, rdata (head, combinational), full, empty, count. The launch FSM and timer live in `uart_tx_feeder`.

## Test plan
- Single byte: push 0xA5 with the controller model idle → `tx_data`=0xA5 with a 1-cycle `tx_data_valid` one edge after the push. The model raises busy 1 edge later and holds it 10 cycles → state returns to IDLE and `feeder_busy`=0.
- Burst to full with DEPTH=8: push 0x01..0x09 back-to-back while the model is held busy → 8 accepted, `in_ready`=0, 0x09 refused, `fifo_count`=8. Release the model → bytes 0x01..0x08 go out in order, one pulse per frame.
- Full with simultaneous pop: FIFO full, launch edge coincides with `in_valid`=1 → push refused, `fifo_count`=7 after that edge.
- Timeout: model never raises busy → `timeout_err` pulses every BUSY_TIMEOUT+1 cycles and `tx_data_valid` repeats with the same byte. The model acks on the third try → exactly one pop, `fifo_count` decremented once.
- Pointer wrap: 20 push/launch cycles with occupancy 1–3 → output order matches input order across the wrap.
- Reset mid-frame: assert `rst` in WAIT_DONE with 3 bytes queued → after the reset edge `fifo_count`=0, `in_ready`=1, `tx_data`=0, no pulse until a new push.
